// File: rtl/byte_class_tracker.sv
// Byte classifier with a 2-entry valid/ready output FIFO and saturating
// per-class event counters selectable onto cnt_val.
module byte_class_tracker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [1:0]       out_ucls,
   output logic [1:0]       out_pcls,
   input  logic             clr,
   input  logic [1:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_val
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; in_ready depends only on FIFO occupancy, never on out_ready.
   typedef struct packed {
      logic [7:0] data;
      logic [1:0] ucls;
      logic [1:0] pcls;
   } entry_t;

   entry_t           head_q, tail_q, in_entry;
   logic [1:0]       count_q;
   logic             push, pop;
   logic [CNT_W-1:0] cnt_q [4];

   always_comb begin
      in_entry      = '0;
      in_entry.data = in_data;
      if (in_data == 8'd0 || in_data == 8'd1)
         in_entry.ucls = 2'd0;
      else if (in_data == 8'd2)
         in_entry.ucls = 2'd1;
      else if (in_data == 8'd4)
         in_entry.ucls = 2'd2;
      else
         in_entry.ucls = 2'd3;
      if (in_data[2:1] == 2'b00)
         in_entry.pcls = 2'd0;
      else if (!in_data[2])
         in_entry.pcls = 2'd1;
      else
         in_entry.pcls = 2'd2;
   end

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data  = out_valid ? head_q.data : 8'd0;
   assign out_ucls  = out_valid ? head_q.ucls : 2'd0;
   assign out_pcls  = out_valid ? head_q.pcls : 2'd0;
   assign cnt_val   = cnt_q[cnt_sel];

   // Push and pop together only happen at occupancy 1 (push needs room, pop
   // needs data), so the new entry simply replaces the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0)
                  head_q <= in_entry;
               else
                  tail_q <= in_entry;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: head_q <= in_entry;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else if (push) begin
         for (int i = 0; i < 4; i++)
            if (in_entry.ucls == 2'(i) && cnt_q[i] != {CNT_W{1'b1}})
               cnt_q[i] <= cnt_q[i] + 1'b1;
      end
   end

endmodule

// File: tb/tb_byte_class_tracker.sv
// Scoreboard bench for byte_class_tracker: driver pushes hand-computed
// {data, ucls, pcls} into exp_q, a negedge monitor pops on every consumed entry.
module tb_byte_class_tracker;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [1:0]       out_ucls;
   logic [1:0]       out_pcls;
   logic             clr;
   logic [1:0]       cnt_sel;
   logic [CNT_W-1:0] cnt_val;

   logic [11:0] exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   byte_class_tracker #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ucls(out_ucls), .out_pcls(out_pcls),
      .clr(clr), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input logic [1:0] sel, input int exp, input string name);
      cnt_sel = sel;
      #1;
      check(name, 32'(cnt_val), exp);
   endtask

   // Called from posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0] d, input logic [1:0] u, input logic [1:0] p,
                       input bit chk_lat);
      int waits = 0;
      exp_q.push_back({d, u, p});
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (chk_lat) begin
         check("latency_valid", 32'(out_valid), 1);
         check("latency_data", 32'(out_data), 32'(d));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_data), 32'hFFFF);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check("sb_entry", 32'({out_data, out_ucls, out_pcls}), 32'(e));
         end
      end
   end

   logic [1:0] sweep_u [8] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3};
   logic [1:0] sweep_p [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
      clr = 1'b0; cnt_sel = 2'd0;
      #3;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_cnt_val", 32'(cnt_val), 0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      // Sweep 0..7 with 1-cycle latency checks
      for (int i = 0; i < 8; i++) send(8'(i), sweep_u[i], sweep_p[i], 1'b1);
      chk_cnt(2'd0, 2, "sweep_cnt0");
      chk_cnt(2'd1, 1, "sweep_cnt1");
      chk_cnt(2'd2, 1, "sweep_cnt2");
      chk_cnt(2'd3, 4, "sweep_cnt3");
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: 5 and 2 fill the FIFO, 9 waits
      out_ready = 1'b0;
      send(8'd5, 2'd3, 2'd2, 1'b0);
      send(8'd2, 2'd1, 2'd1, 1'b0);
      in_valid = 1'b1; in_data = 8'd9;
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 0);
      fork
         send(8'd9, 2'd3, 2'd0, 1'b0);
         begin
            repeat (2) begin
               @(negedge clk);
               check("bp_hold_data", 32'({out_valid, out_data}), 32'h105);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Saturation at 2^3-1
      clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
      repeat (10) send(8'd4, 2'd2, 2'd2, 1'b0);
      chk_cnt(2'd2, 7, "sat_cnt2");

      // clr on the accepting edge wins
      clr = 1'b1;
      send(8'd2, 2'd1, 2'd1, 1'b0);
      clr = 1'b0;
      chk_cnt(2'd1, 0, "clr_coll_cnt1");
      chk_cnt(2'd2, 0, "clr_coll_cnt2");
      send(8'd2, 2'd1, 2'd1, 1'b0);
      chk_cnt(2'd1, 1, "post_clr_cnt1");
      repeat (3) @(posedge clk);
      #1;
      check("drain_before_reset", 32'(exp_q.size()), 0);

      // Mid-operation asynchronous reset with two entries queued
      out_ready = 1'b0;
      send(8'd7, 2'd3, 2'd2, 1'b0);
      send(8'd3, 2'd3, 2'd1, 1'b0);
      chk_cnt(2'd3, 2, "pre_rst_cnt3");
      #2 rst_n = 1'b0;
      #1;
      check("mrst_out_valid", 32'(out_valid), 0);
      check("mrst_out_fields", 32'({out_data, out_ucls, out_pcls}), 0);
      check("mrst_in_ready", 32'(in_ready), 1);
      for (int s = 0; s < 4; s++) chk_cnt(2'(s), 0, "mrst_cnt");
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'd6, 2'd3, 2'd2, 1'b1);
      chk_cnt(2'd3, 1, "post_rst_cnt3");
      repeat (3) @(posedge clk);
      #1;
      check("final_drain", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/byte_class_tracker.md
BYTE_CLASS_TRACKER -- requirements
Module: byte_class_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-class event counter.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1: upstream byte available.
REQ-005 SHALL have port in_data, input, 8: byte value to classify.
REQ-006 SHALL have port in_ready, output, 1: block can accept a byte.
REQ-007 SHALL have port out_valid, output, 1: classified entry available.
REQ-008 SHALL have port out_ready, input, 1: downstream consumes the entry.
REQ-009 SHALL have port out_data, output, 8: the original byte.
REQ-010 SHALL have port out_ucls, output, 2: exclusive value class.
REQ-011 SHALL have port out_pcls, output, 2: priority bit-field class.
REQ-012 SHALL have port clr, input, 1: synchronous counter clear.
REQ-013 SHALL have port cnt_sel, input, 2: selects the exclusive-class counter shown on cnt_val.
REQ-014 SHALL have port cnt_val, output, CNT_W: combinational view of the selected counter.

Function
REQ-015 SHALL accept a byte on a rising clk edge when in_valid=1 and in_ready=1, and at no other time.
REQ-016 SHALL compute out_ucls with mutually exclusive conditions: 0 if in_data is 0 or 1; 1 if in_data==2; 2 if in_data==4; 3 otherwise.
REQ-017 SHALL compute out_pcls in order of precedence: 0 if in_data[2:1]==00; 1 if in_data[2]==0 (that is, [2:1]==01); 2 otherwise. Code 3 is never produced.
REQ-018 SHALL register the classification at acceptance into a 2-entry FIFO holding {data, ucls, pcls}.
REQ-019 SHALL present the FIFO head on out_data, out_ucls and out_pcls, with out_valid=1 whenever the FIFO is non-empty.
REQ-020 SHALL give a latency of exactly 1 cycle: a byte accepted at edge N drives out_valid=1 after edge N when the FIFO was empty.
REQ-021 SHALL pop the head on an edge where out_valid=1 and out_ready=1.
REQ-022 SHALL drive in_ready=1 exactly when the FIFO holds fewer than 2 entries; in_ready has no combinational dependency on out_ready.
REQ-023 SHALL handle simultaneous push and pop at occupancy 1 by keeping occupancy 1, popping the old head and making the new entry the head.
REQ-024 SHALL handle a pop at occupancy 2 with no push by reducing occupancy to 1; the second entry becomes head next cycle.
REQ-025 SHALL hold out_data, out_ucls and out_pcls stable while out_valid=1 and out_ready=0.
REQ-026 SHALL keep four counters cnt[0..3]; each accepted byte increments cnt[ucls] by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL zero all four counters on an edge where clr=1; a byte accepted on that same edge is not counted (clr takes precedence).
REQ-028 SHALL drive cnt_val = cnt[cnt_sel] combinationally.
REQ-029 SHALL leave FIFO contents and handshakes unaffected by clr.
REQ-030 SHALL drive out_data, out_ucls and out_pcls to 0 while out_valid=0.

Reset
REQ-031 SHALL respond to rst_n=0 immediately, independent of clk, by emptying the FIFO, zeroing all counters and driving out_valid=0, out_data=0, out_ucls=0, out_pcls=0 and cnt_val=0.
REQ-032 SHALL drive in_ready=1 while rst_n=0.
REQ-033 SHALL discard any in-flight entries on reset asserted mid-transfer, and accept no byte on the edge where rst_n deasserts.

Verification
REQ-034 SHALL be covered by a sweep: in_data=0..7, one per cycle, out_ready=1 -> out_ucls sequence 0,0,1,3,2,3,3,3; out_pcls sequence 0,0,1,1,2,2,2,2; each output appears 1 cycle after acceptance; then cnt[0..3]=2,1,1,4.
REQ-035 SHALL be covered by a backpressure test: out_ready=0, push 5, 2, 9 -> 5 and 2 accepted, in_ready=0 afterwards, 9 held off; out_ready=1 -> outputs 5 then 2, then 9 accepted and output in order.
REQ-036 SHALL be covered by a saturation test: CNT_W=3, push 10 bytes of value 4 -> cnt[2] reads 7 (not wrapped).
REQ-037 SHALL be covered by a clr collision test: clr=1 on the same edge as accepting 2 -> cnt[1]=0, and byte 2 still emerges with out_ucls=1.
REQ-038 SHALL be covered by a mid-operation reset test: rst_n pulsed low asynchronously with 2 entries queued -> out_valid=0 and all counters 0 immediately; after release, the first new byte appears with 1-cycle latency.
